// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide engine that owns the architectural Hi/Lo pair.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, followed by a
// sign-fix cycle that loads Hi/Lo. Stall holds an ID-stage mfhi/mflo until the result lands.
// Build option: define MULDIV_DIV_EN to include the divide datapath and the DivByZero flag;
// without it, div/divu issues are ignored and DivByZero is tied low.
module muldiv_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              Flush,
  input  logic              HiLoRead,
  output logic              Busy,
  output logic              Stall,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Done,
  output logic              DivByZero
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} stateE;

  stateE             state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] aReg;     // multiplicand, or dividend shifting out MSB-first
  logic [DATA_W-1:0] bReg;     // multiplier shifting out LSB-first, or divisor
  logic              signA;
  logic              signB;
  logic              isSigned;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;

  logic              canStart;
  logic              legalOp;
  logic              accept;
  logic              opSigned;
  logic [DATA_W-1:0] magA;
  logic [DATA_W-1:0] magB;
  logic [DATA_W:0]   mulSum;
  logic [ACC_W-1:0]  accStep;
  logic [DATA_W-1:0] aStep;
  logic [DATA_W-1:0] bStep;
  logic [ACC_W-1:0]  mulFix;

`ifdef MULDIV_DIV_EN
  logic              isDiv;
  logic              divZero;
  logic              dbzReg;
  logic [DATA_W:0]   remTmp;
  logic [DATA_W:0]   divDiff;
  logic              qBit;
  logic [DATA_W-1:0] newRem;
  logic [DATA_W-1:0] quotFix;
  logic [DATA_W-1:0] remFix;
`endif

  // Issue decode, operand magnitudes and one iteration step of the active datapath.
  always_comb begin
    canStart = (state == StIdle) || (state == StDone);
`ifdef MULDIV_DIV_EN
    legalOp  = 1'b1;
`else
    legalOp  = ~Op[1];
`endif
    accept   = Start & ~Flush & legalOp & canStart;
    opSigned = ~Op[0];
    magA     = (opSigned & OperandA[DATA_W-1]) ? -OperandA : OperandA;
    magB     = (opSigned & OperandB[DATA_W-1]) ? -OperandB : OperandB;

    // Right-shifting multiply: add multiplicand into the high half, shift the whole pair.
    mulSum   = {1'b0, acc[ACC_W-1:DATA_W]} + (bReg[0] ? {1'b0, aReg} : '0);
    accStep  = {mulSum, acc[DATA_W-1:1]};
    aStep    = aReg;
    bStep    = bReg >> 1;
    mulFix   = (isSigned & (signA ^ signB)) ? -acc : acc;

`ifdef MULDIV_DIV_EN
    // Restoring divide: remainder in the high half, quotient bits enter the low half.
    remTmp   = {acc[ACC_W-1:DATA_W], aReg[DATA_W-1]};
    divDiff  = remTmp - {1'b0, bReg};
    qBit     = ~divDiff[DATA_W];
    newRem   = qBit ? divDiff[DATA_W-1:0] : remTmp[DATA_W-1:0];
    quotFix  = (isSigned & (signA ^ signB)) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    remFix   = (isSigned & signA) ? -acc[ACC_W-1:DATA_W] : acc[ACC_W-1:DATA_W];
    if (isDiv) begin
      accStep = {newRem, acc[DATA_W-2:0], qBit};
      aStep   = aReg << 1;
      bStep   = bReg;
    end
`endif
  end

  // Sequencer FSM with the iteration registers and the architectural Hi/Lo pair.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= StIdle;
      cnt      <= '0;
      acc      <= '0;
      aReg     <= '0;
      bReg     <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      isSigned <= 1'b0;
      hiReg    <= '0;
      loReg    <= '0;
`ifdef MULDIV_DIV_EN
      isDiv    <= 1'b0;
      divZero  <= 1'b0;
      dbzReg   <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle, StDone: begin
          if (accept) begin
            cnt      <= '0;
            acc      <= '0;
            aReg     <= magA;
            bReg     <= magB;
            signA    <= opSigned & OperandA[DATA_W-1];
            signB    <= opSigned & OperandB[DATA_W-1];
            isSigned <= opSigned;
            state    <= StRun;
`ifdef MULDIV_DIV_EN
            dbzReg   <= 1'b0;
            isDiv    <= Op[1];
            divZero  <= Op[1] & (OperandB == '0);
            // Divide by zero skips iteration; Hi reports the raw dividend.
            if (Op[1] && (OperandB == '0)) begin
              aReg  <= OperandA;
              state <= StFix;
            end
`endif
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          if (Flush) begin
            state <= StIdle;
          end else begin
            acc  <= accStep;
            aReg <= aStep;
            bReg <= bStep;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state <= StFix;
          end
        end
        StFix: begin
          if (Flush) begin
            state <= StIdle;
          end else begin
            {hiReg, loReg} <= mulFix;
`ifdef MULDIV_DIV_EN
            if (divZero) begin
              hiReg  <= aReg;
              loReg  <= '1;
              dbzReg <= 1'b1;
            end else if (isDiv) begin
              hiReg <= remFix;
              loReg <= quotFix;
            end
`endif
            state <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign Busy  = (state == StRun) || (state == StFix);
  assign Done  = (state == StDone);
  assign Stall = HiLoRead & (Busy | accept);
  assign Hi    = hiReg;
  assign Lo    = loReg;
`ifdef MULDIV_DIV_EN
  assign DivByZero = dbzReg;
`else
  assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer. Expected Hi/Lo/DivByZero and the
// due cycle are queued at issue and popped when Done pulses.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         Flush = 1'b0;
  logic         HiLoRead = 1'b0;
  logic         Busy;
  logic         Stall;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Done;
  logic         DivByZero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int unsigned  due;
  } expT;

  expT          sb[$];
  expT          monEntry;
  int unsigned  cyc = 0;
  int unsigned  nCompared = 0;
  int unsigned  nMismatched = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;

  muldiv_sequencer #(.DATA_W(W), .CNT_W(6)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .Flush     (Flush),
    .HiLoRead  (HiLoRead),
    .Busy      (Busy),
    .Stall     (Stall),
    .Hi        (Hi),
    .Lo        (Lo),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every Done pulse must match the oldest outstanding issue.
  always @(negedge Clk) begin
    if (Reset && Done) begin
      if (sb.size() == 0) begin
        check("unexpected Done", 64'd1, 64'd0);
      end else begin
        monEntry = sb.pop_front();
        check("Hi", Hi, monEntry.hi);
        check("Lo", Lo, monEntry.lo);
        check("DivByZero", DivByZero, monEntry.dbz);
        check("latency", cyc, monEntry.due);
        lastHi = monEntry.hi;
        lastLo = monEntry.lo;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive Start for the current cycle and queue the result the model expects.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                       input logic expDbz, input int unsigned lat);
    expT e;
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    e.hi  = expHi;
    e.lo  = expLo;
    e.dbz = expDbz;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic issuePulse(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                            input logic expDbz, input int unsigned lat);
    issue(op, a, b, expHi, expLo, expDbz, lat);
    tick();
    Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 64'd0);
    sb.delete();
    tick();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [63:0]  prod;
    longint       sp;

    // Reset values
    tick();
    tick();
    check("rst Busy", Busy, 0);
    check("rst Done", Done, 0);
    check("rst Hi", Hi, 0);
    check("rst Lo", Lo, 0);
    check("rst DivByZero", DivByZero, 0);
    Reset = 1'b1;
    tick();

    // multu all-ones squared
    issuePulse(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    drain();

    // mult -7 x 3, then back-to-back -2^31 x -2^31 issued in the DONE cycle
    issuePulse(2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    repeat (33) tick();
    check("Done before b2b", Done, 1);
    issuePulse(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
    check("b2b Busy", Busy, 1);
    drain();

    // Random mult/multu against 64-bit arithmetic
    for (int i = 0; i < 4; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      prod = {32'h0, ra} * {32'h0, rb};
      issuePulse(2'b01, ra, rb, prod[63:32], prod[31:0], 1'b0, 34);
      drain();
      sp   = longint'($signed(ra)) * longint'($signed(rb));
      prod = sp;
      issuePulse(2'b00, ra, rb, prod[63:32], prod[31:0], 1'b0, 34);
      drain();
    end

`ifdef MULDIV_DIV_EN
    issuePulse(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    drain();
    issuePulse(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
    drain();
    issuePulse(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    drain();
    issuePulse(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);
    drain();
    repeat (3) tick();
    check("DivByZero sticky", DivByZero, 1);
    issuePulse(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);
    check("DivByZero cleared", DivByZero, 0);
    drain();
`else
    // Without the divide datapath a div issue is ignored
    HiLoRead = 1'b1;
    Start    = 1'b1;
    Op       = 2'b11;
    OperandA = 32'd5;
    OperandB = 32'd0;
    #1;
    check("div ignored Stall", Stall, 0);
    tick();
    Start    = 1'b0;
    HiLoRead = 1'b0;
    check("div ignored Busy", Busy, 0);
    repeat (5) tick();
    check("div ignored Hi", Hi, lastHi);
    check("div ignored Lo", Lo, lastLo);
    check("div ignored DivByZero", DivByZero, 0);
`endif

    // Stall profile with HiLoRead held, plus an ignored Start mid-operation
    HiLoRead = 1'b1;
    issue(2'b01, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 34);
    #1;
    check("Stall c0", Stall, 1);
    for (int k = 1; k <= 34; k++) begin
      tick();
      Start = 1'b0;
      if (k == 5) begin
        Start    = 1'b1;
        Op       = 2'b01;
        OperandA = 32'd7;
        OperandB = 32'd9;
      end
      #1;
      check($sformatf("Stall c%0d", k), Stall, (k < 34) ? 1 : 0);
    end
    HiLoRead = 1'b0;
    Start    = 1'b0;
    drain();

    // Flush at RUN cycle 10
    issuePulse(2'b01, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 34);
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush Busy", Busy, 0);
    sb.delete();
    repeat (40) tick();
    check("flush Hi", Hi, lastHi);
    check("flush Lo", Lo, lastLo);

    // Flush and Start together
    Start    = 1'b1;
    Flush    = 1'b1;
    HiLoRead = 1'b1;
    Op       = 2'b01;
    OperandA = 32'd3;
    OperandB = 32'd3;
    #1;
    check("flush+start Stall", Stall, 0);
    tick();
    Start    = 1'b0;
    Flush    = 1'b0;
    HiLoRead = 1'b0;
    check("flush+start Busy", Busy, 0);
    repeat (40) tick();
    check("flush+start Lo", Lo, lastLo);

    // Reset asserted mid-RUN
    issuePulse(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34);
    repeat (5) tick();
    Reset    = 1'b0;
    HiLoRead = 1'b1;
    #1;
    sb.delete();
    check("midrst Busy", Busy, 0);
    check("midrst Done", Done, 0);
    check("midrst Hi", Hi, 0);
    check("midrst Lo", Lo, 0);
    check("midrst Stall", Stall, 0);
    check("midrst DivByZero", DivByZero, 0);
    lastHi = '0;
    lastLo = '0;
    tick();
    Reset    = 1'b1;
    HiLoRead = 1'b0;
    tick();
    check("post-rst Busy", Busy, 0);
    repeat (40) tick();
    check("post-rst Lo", Lo, 0);

    // Recovery after reset
    issuePulse(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 1'b0, 34);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
